// File: rtl/id_stage_if.sv
// Handshake and data buses around the decode stage: fetch in, execute out,
// write-back port into the register file and branch redirect back to fetch.
interface id_stage_if;
  logic         if_validout;
  logic         id_allowin;
  logic [63:0]  if_to_id_bus;
  logic         id_validout;
  logic         exe_allowin;
  logic [149:0] id_to_exe_bus;
  logic [32:0]  br_bus;
  logic [37:0]  ws_to_rf_bus;

  modport master (
    output if_validout, if_to_id_bus, exe_allowin, ws_to_rf_bus,
    input  id_allowin, id_validout, id_to_exe_bus, br_bus
  );

  modport slave (
    input  if_validout, if_to_id_bus, exe_allowin, ws_to_rf_bus,
    output id_allowin, id_validout, id_to_exe_bus, br_bus
  );
endinterface

// File: rtl/id_stage.sv
// LoongArch32 decode stage: pipeline register, decoder, 32x32 register file
// and branch resolution with squash of the instruction fetched behind a taken branch.
module id_stage (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave id_io
);
  logic        valid_q, valid_d;
  logic        br_cancel_q, br_cancel_d;
  logic [63:0] payload_q, payload_d;
  logic [31:0] rf_q [32];

  logic [31:0] pc, inst;
  logic [4:0]  rd, rj, rk, rkd_addr, dest;
  logic [31:0] rj_value, rkd_value, imm, offs16, offs26, br_target;
  logic [11:0] alu_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fetch_accept, br_taken, br_leave, rj_eq_rkd;
  logic        src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we;

  logic inst_add_w, inst_sub_w, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
  logic inst_slli_w, inst_srli_w, inst_srai_w, inst_addi_w, inst_lu12i_w, inst_ld_w, inst_st_w;
  logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne;

  assign {pc, inst} = payload_q;
  assign {rf_we, rf_waddr, rf_wdata} = id_io.ws_to_rf_bus;
  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  assign inst_add_w   = inst[31:15] == 17'h00020;
  assign inst_sub_w   = inst[31:15] == 17'h00022;
  assign inst_slt     = inst[31:15] == 17'h00024;
  assign inst_sltu    = inst[31:15] == 17'h00025;
  assign inst_nor     = inst[31:15] == 17'h00028;
  assign inst_and     = inst[31:15] == 17'h00029;
  assign inst_or      = inst[31:15] == 17'h0002a;
  assign inst_xor     = inst[31:15] == 17'h0002b;
  assign inst_slli_w  = inst[31:15] == 17'h00081;
  assign inst_srli_w  = inst[31:15] == 17'h00089;
  assign inst_srai_w  = inst[31:15] == 17'h00091;
  assign inst_addi_w  = inst[31:22] == 10'h00a;
  assign inst_lu12i_w = inst[31:25] == 7'h0a;
  assign inst_ld_w    = inst[31:22] == 10'h0a2;
  assign inst_st_w    = inst[31:22] == 10'h0a6;
  assign inst_jirl    = inst[31:26] == 6'h13;
  assign inst_b       = inst[31:26] == 6'h14;
  assign inst_bl      = inst[31:26] == 6'h15;
  assign inst_beq     = inst[31:26] == 6'h16;
  assign inst_bne     = inst[31:26] == 6'h17;

  // alu_op one-hot, bit 0 upward: add sub slt sltu and nor or xor sll srl sra lui
  assign alu_op = {inst_lu12i_w, inst_srai_w, inst_srli_w, inst_slli_w, inst_xor, inst_or,
                   inst_nor, inst_and, inst_sltu, inst_slt, inst_sub_w,
                   inst_add_w | inst_addi_w | inst_ld_w | inst_st_w | inst_jirl | inst_bl};

  assign src1_is_pc   = inst_jirl | inst_bl;
  assign src2_is_imm  = inst_slli_w | inst_srli_w | inst_srai_w | inst_addi_w | inst_lu12i_w
                      | inst_ld_w | inst_st_w | inst_jirl | inst_bl;
  assign res_from_mem = inst_ld_w;
  assign mem_we       = inst_st_w;
  assign gr_we        = inst_add_w | inst_sub_w | inst_slt | inst_sltu | inst_and | inst_or
                      | inst_nor | inst_xor | inst_slli_w | inst_srli_w | inst_srai_w
                      | inst_addi_w | inst_lu12i_w | inst_ld_w | inst_jirl | inst_bl;
  assign dest         = gr_we ? (inst_bl ? 5'd1 : rd) : 5'd0;

  always_comb begin
    imm = 32'h0;
    if (inst_addi_w | inst_ld_w | inst_st_w) imm = {{20{inst[21]}}, inst[21:10]};
    else if (inst_slli_w | inst_srli_w | inst_srai_w) imm = {27'h0, inst[14:10]};
    else if (inst_lu12i_w) imm = {inst[24:5], 12'h0};
    else if (inst_bl | inst_jirl) imm = 32'd4;
  end

  assign rkd_addr  = (inst_st_w | inst_beq | inst_bne) ? rd : rk;
  assign rj_value  = (rj == 5'd0) ? 32'h0 : rf_q[rj];
  assign rkd_value = (rkd_addr == 5'd0) ? 32'h0 : rf_q[rkd_addr];

  assign offs16    = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign rj_eq_rkd = rj_value == rkd_value;
  assign br_target = inst_jirl ? rj_value + offs16
                               : pc + ((inst_b | inst_bl) ? offs26 : offs16);
  assign br_taken  = valid_q & (inst_b | inst_bl | inst_jirl
                              | (inst_beq & rj_eq_rkd) | (inst_bne & ~rj_eq_rkd));

  assign id_io.id_allowin    = ~valid_q | id_io.exe_allowin;
  assign id_io.id_validout   = valid_q;
  assign id_io.br_bus        = {br_taken, br_taken ? br_target : 32'h0};
  assign id_io.id_to_exe_bus = {alu_op, src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we,
                                dest, imm, rj_value, rkd_value, pc};

  // The slot behind a taken branch is squashed either in the same cycle the
  // branch leaves or, if fetch had nothing then, on the next accept.
  assign fetch_accept = id_io.if_validout & id_io.id_allowin;
  assign br_leave     = br_taken & id_io.exe_allowin;
  assign valid_d      = id_io.if_validout & ~(br_cancel_q | br_leave);
  assign br_cancel_d  = fetch_accept ? 1'b0 : (br_leave | br_cancel_q);
  assign payload_d    = fetch_accept ? id_io.if_to_id_bus : payload_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      br_cancel_q <= 1'b0;
      payload_q   <= 64'h0;
    end else begin
      if (id_io.id_allowin) valid_q <= valid_d;
      br_cancel_q <= br_cancel_d;
      payload_q   <= payload_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected {br_bus, id_to_exe_bus} entries are
// queued on fetch acceptance and compared when the instruction leaves to EXE.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if io();
  id_stage dut (.clk(clk), .rst(rst), .id_io(io));

  int checks = 0;
  int errors = 0;
  logic [182:0] sb [$];
  logic [31:0]  rf_model [32];
  bit           cur_push;
  logic [182:0] cur_exp;
  bit           accepted;
  logic [182:0] exp_st;

  task automatic chk(input string tag, input logic [182:0] obs, input logic [182:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [182:0] mk(input logic br_t, input logic [31:0] br_tgt,
      input logic [11:0] aop, input logic s1pc, input logic s2imm, input logic rfm,
      input logic grwe, input logic mwe, input logic [4:0] dest, input logic [31:0] imm,
      input logic [31:0] rjv, input logic [31:0] rkdv, input logic [31:0] pc);
    return {br_t, br_tgt, aop, s1pc, s2imm, rfm, grwe, mwe, dest, imm, rjv, rkdv, pc};
  endfunction

  task automatic tick();
    logic [182:0] e;
    @(negedge clk);
    if (io.id_validout && io.exe_allowin) begin
      if (sb.size() == 0) chk("unexpected_out", {182'h0, io.id_validout}, 183'h0);
      else begin
        e = sb.pop_front();
        chk("br_bus", {150'h0, io.br_bus}, {150'h0, e[182:150]});
        chk("exe_bus", {33'h0, io.id_to_exe_bus}, {33'h0, e[149:0]});
      end
    end
    if (io.if_validout && io.id_allowin) begin
      accepted = 1'b1;
      if (cur_push) sb.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input bit push,
                       input logic [182:0] exp);
    io.if_validout  = 1'b1;
    io.if_to_id_bus = {pc, inst};
    cur_push = push;
    cur_exp  = exp;
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) tick();
    chk("accept", {182'h0, accepted}, 183'h1);
    io.if_validout = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    io.ws_to_rf_bus = {1'b1, a, d};
    tick();
    io.ws_to_rf_bus = 38'h0;
    if (a != 5'd0) rf_model[a] = d;
  endtask

  initial begin
    logic [31:0] i_st;
    rst = 1'b1;
    io.if_validout = 1'b0;
    io.if_to_id_bus = 64'h0;
    io.exe_allowin = 1'b1;
    io.ws_to_rf_bus = 38'h0;
    rf_model[0] = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_validout", {182'h0, io.id_validout}, 183'h0);
    chk("rst_allowin", {182'h0, io.id_allowin}, 183'h1);
    chk("rst_br_bus", {150'h0, io.br_bus}, 183'h0);
    chk("rst_exe_bus", {33'h0, io.id_to_exe_bus}, 183'h0);

    for (int r = 1; r < 32; r++) wb_write(r[4:0], 32'hA000_0000 + r);

    // addi.w r1, r0, 5
    offer(32'h1c000000, 32'h02801401, 1'b1,
          mk(0, 0, 12'h001, 0, 1, 0, 1, 0, 5'd1, 32'd5, 32'h0, rf_model[5], 32'h1c000000));
    tick();

    // beq r2, r3, +8 with equal operands: taken, sequential slot squashed
    wb_write(5'd2, 32'h7);
    wb_write(5'd3, 32'h7);
    offer(32'h1c000010, {6'h16, 16'd2, 5'd2, 5'd3}, 1'b1,
          mk(1, 32'h1c000018, 12'h000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h7, 32'h7, 32'h1c000010));
    offer(32'h1c000014, 32'h02801401, 1'b0, 183'h0);
    tick();
    chk("squash_beq", {182'h0, io.id_validout}, 183'h0);
    // add.w r4, r2, r3 at the branch target
    offer(32'h1c000018, {17'h00020, 5'd3, 5'd2, 5'd4}, 1'b1,
          mk(0, 0, 12'h001, 0, 0, 0, 1, 0, 5'd4, 32'h0, 32'h7, 32'h7, 32'h1c000018));
    tick();

    // bne r2, r3 with equal operands: not taken, next flows
    offer(32'h1c00001c, {6'h17, 16'd2, 5'd2, 5'd3}, 1'b1,
          mk(0, 0, 12'h000, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h7, 32'h7, 32'h1c00001c));
    // srai.w r6, r1, 3
    offer(32'h1c000020, {17'h00091, 5'd3, 5'd1, 5'd6}, 1'b1,
          mk(0, 0, 12'h400, 0, 1, 0, 1, 0, 5'd6, 32'd3, rf_model[1], rf_model[3], 32'h1c000020));
    tick();

    // bl -4: leaves with no offer pending, so the cancel waits for the next accept
    offer(32'h1c000100, 32'h57ffffff, 1'b1,
          mk(1, 32'h1c0000fc, 12'h001, 1, 1, 0, 1, 0, 5'd1, 32'd4, rf_model[31], rf_model[31],
             32'h1c000100));
    tick();
    chk("bl_gone", {182'h0, io.id_validout}, 183'h0);
    offer(32'h1c000104, 32'hffffffff, 1'b0, 183'h0);
    tick();
    chk("squash_bl", {182'h0, io.id_validout}, 183'h0);
    // unsupported encoding decodes as NOP
    offer(32'h1c0000fc, 32'hffffffff, 1'b1,
          mk(0, 0, 12'h000, 0, 0, 0, 0, 0, 5'd0, 32'h0, rf_model[31], rf_model[31], 32'h1c0000fc));
    tick();

    // jirl r1, r2, +4 -> r2 + 4
    offer(32'h1c000200, {6'h13, 16'd1, 5'd2, 5'd1}, 1'b1,
          mk(1, 32'h0000000b, 12'h001, 1, 1, 0, 1, 0, 5'd1, 32'd4, 32'h7, rf_model[1],
             32'h1c000200));
    offer(32'h1c000204, 32'h02801401, 1'b0, 183'h0);
    tick();
    chk("squash_jirl", {182'h0, io.id_validout}, 183'h0);

    // r0 stays zero after a write attempt
    wb_write(5'd0, 32'hffffffff);

    // st.w r5, r1, -8 held three cycles by EXE
    i_st = {10'h0a6, 12'hff8, 5'd1, 5'd5};
    exp_st = mk(0, 0, 12'h001, 0, 1, 0, 0, 1, 5'd0, 32'hfffffff8, rf_model[1], rf_model[5],
                32'h1c000300);
    offer(32'h1c000300, i_st, 1'b1, exp_st);
    io.exe_allowin = 1'b0;
    io.if_validout = 1'b1;
    io.if_to_id_bus = {32'h1c000304, 32'h00100004};
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_allowin", {182'h0, io.id_allowin}, 183'h0);
      chk("stall_validout", {182'h0, io.id_validout}, 183'h1);
      chk("stall_exe_bus", {33'h0, io.id_to_exe_bus}, {33'h0, exp_st[149:0]});
    end
    io.exe_allowin = 1'b1;
    // add.w r4, r0, r0
    offer(32'h1c000304, 32'h00100004, 1'b1,
          mk(0, 0, 12'h001, 0, 0, 0, 1, 0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h1c000304));
    tick();

    // held b +16 keeps br_bus up under stall, then reset drops it
    io.exe_allowin = 1'b0;
    offer(32'h1c000400, {6'h14, 16'd4, 10'd0}, 1'b0, 183'h0);
    tick();
    chk("held_b_br_bus", {150'h0, io.br_bus}, {150'h0, 1'b1, 32'h1c000410});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_validout", {182'h0, io.id_validout}, 183'h0);
    chk("midrst_allowin", {182'h0, io.id_allowin}, 183'h1);
    chk("midrst_br_bus", {150'h0, io.br_bus}, 183'h0);
    io.exe_allowin = 1'b1;
    offer(32'h1c000500, 32'h02801401, 1'b1,
          mk(0, 0, 12'h001, 0, 1, 0, 1, 0, 5'd1, 32'd5, 32'h0, rf_model[5], 32'h1c000500));
    tick();
    tick();

    chk("sb_empty", {151'h0, sb.size()}, 183'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
